// File: rtl/writeback_arbiter_if.sv
// Writeback bundle: ALU/LSU results in, register-file write port and scoreboard queries out.
// master drives results and queries; slave is the arbiter.
interface writeback_arbiter_if;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        lsu_ready;
   logic        rf_write_en;
   logic [4:0]  rf_write_id;
   logic [31:0] rf_write_data;
   logic [4:0]  query1_id;
   logic [4:0]  query2_id;
   logic        busy1;
   logic        busy2;

   modport master (
      output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, query1_id, query2_id,
      input  lsu_ready, rf_write_en, rf_write_id, rf_write_data, busy1, busy2
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, query1_id, query2_id,
      output lsu_ready, rf_write_en, rf_write_id, rf_write_data, busy1, busy2
   );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges ALU and buffered LSU results onto one register-file write port; write lands one cycle after selection.
// ALU is never stalled; LSU is back-pressured by lsu_ready = registered count < DEPTH.
module writeback_arbiter #(
   parameter int DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   writeback_arbiter_if.slave   wb
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef struct packed {
      logic        live;
      logic [4:0]  rd;
      logic [31:0] data;
   } entry_t;

   entry_t        entries [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;

   entry_t      head;
   logic        alu_sel;
   logic        lsu_wr;
   logic        head_live;
   logic        bypass;
   logic        deq;
   logic        enq;
   logic        sel_en;
   logic [4:0]  sel_id;
   logic [31:0] sel_data;
   logic        hit1;
   logic        hit2;

   assign wb.lsu_ready = reset_n && (count < FULL_CNT);

   always_comb begin
      head      = entries[rd_ptr];
      alu_sel   = wb.alu_valid && (wb.alu_rd != 5'd0);
      lsu_wr    = wb.lsu_valid && wb.lsu_ready && (wb.lsu_rd != 5'd0);
      head_live = (count != '0) && head.live;
      // A dead sole entry is popped this cycle, so the FIFO counts as empty for bypass.
      bypass    = !alu_sel && lsu_wr &&
                  ((count == '0) || ((count == CW'(1)) && !head.live));
      deq       = !alu_sel && (count != '0);
      enq       = lsu_wr && !bypass;

      sel_en   = 1'b0;
      sel_id   = wb.alu_rd;
      sel_data = wb.alu_data;
      if (alu_sel) begin
         sel_en = 1'b1;
      end else if (head_live) begin
         sel_en   = 1'b1;
         sel_id   = head.rd;
         sel_data = head.data;
      end else if (bypass) begin
         sel_en   = 1'b1;
         sel_id   = wb.lsu_rd;
         sel_data = wb.lsu_data;
      end
   end

   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entries[i].live && (entries[i].rd == wb.query1_id)) hit1 = 1'b1;
         if (entries[i].live && (entries[i].rd == wb.query2_id)) hit2 = 1'b1;
      end
   end

   assign wb.busy1 = reset_n && (wb.query1_id != 5'd0) && hit1;
   assign wb.busy2 = reset_n && (wb.query2_id != 5'd0) && hit2;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count            <= '0;
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         wb.rf_write_en   <= 1'b0;
         wb.rf_write_id   <= 5'd0;
         wb.rf_write_data <= 32'd0;
         for (int i = 0; i < DEPTH; i++) entries[i].live <= 1'b0;
      end else begin
         wb.rf_write_en <= sel_en;
         if (sel_en) begin
            wb.rf_write_id   <= sel_id;
            wb.rf_write_data <= sel_data;
         end
         // A younger ALU write makes any older pending result for the same rd obsolete.
         for (int i = 0; i < DEPTH; i++) begin
            if (alu_sel && (entries[i].rd == wb.alu_rd)) entries[i].live <= 1'b0;
         end
         if (deq) begin
            entries[rd_ptr].live <= 1'b0;
            rd_ptr               <= rd_ptr + PW'(1);
         end
         if (enq) begin
            entries[wr_ptr] <= '{live: !(alu_sel && (wb.lsu_rd == wb.alu_rd)),
                                 rd: wb.lsu_rd, data: wb.lsu_data};
            wr_ptr          <= wr_ptr + PW'(1);
         end
         count <= count + CW'(enq) - CW'(deq);
      end
   end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomised and directed stimulus for writeback_arbiter, checked every cycle against a queue-based model.
module tb_writeback_arbiter;
   localparam int DEPTH = 2;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      bit          live;
   } ent_t;

   logic clk = 1'b0;
   logic reset_n;
   writeback_arbiter_if wb();

   writeback_arbiter #(.DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .wb      (wb)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   ent_t        q[$];
   logic        exp_en;
   logic [4:0]  exp_id;
   logic [31:0] exp_data;
   bit          off_vld;
   logic [4:0]  off_rd;
   logic [31:0] off_data;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic bit m_busy(input logic [4:0] id);
      if (!reset_n || id == 5'd0) return 1'b0;
      foreach (q[i]) if (q[i].live && q[i].rd == id) return 1'b1;
      return 1'b0;
   endfunction

   // One cycle of the result-merging rules applied to the pending-result queue.
   task automatic m_step(output bit acc);
      bit asel;
      bit lwr;
      bit wrote;
      ent_t e;
      acc = 1'b0;
      if (!reset_n) begin
         q.delete();
         exp_en   = 1'b0;
         exp_id   = 5'd0;
         exp_data = 32'd0;
         return;
      end
      acc    = wb.lsu_valid && (q.size() < DEPTH);
      asel   = wb.alu_valid && wb.alu_rd != 5'd0;
      lwr    = acc && wb.lsu_rd != 5'd0;
      exp_en = 1'b0;
      wrote  = 1'b0;
      if (asel) begin
         foreach (q[i]) if (q[i].rd == wb.alu_rd) q[i].live = 1'b0;
         exp_en   = 1'b1;
         exp_id   = wb.alu_rd;
         exp_data = wb.alu_data;
         if (lwr) q.push_back('{rd: wb.lsu_rd, data: wb.lsu_data, live: wb.lsu_rd != wb.alu_rd});
      end else begin
         if (q.size() > 0) begin
            e = q.pop_front();
            if (e.live) begin
               exp_en   = 1'b1;
               exp_id   = e.rd;
               exp_data = e.data;
               wrote    = 1'b1;
            end
         end
         if (lwr) begin
            if (!wrote && q.size() == 0) begin
               exp_en   = 1'b1;
               exp_id   = wb.lsu_rd;
               exp_data = wb.lsu_data;
            end else begin
               q.push_back('{rd: wb.lsu_rd, data: wb.lsu_data, live: 1'b1});
            end
         end
      end
   endtask

   task automatic drv(input bit av, input logic [4:0] ard, input logic [31:0] adat,
                      input logic [4:0] q1, input logic [4:0] q2);
      wb.alu_valid = av;
      wb.alu_rd    = ard;
      wb.alu_data  = adat;
      wb.query1_id = q1;
      wb.query2_id = q2;
   endtask

   task automatic offer(input logic [4:0] rd, input logic [31:0] data);
      off_vld  = 1'b1;
      off_rd   = rd;
      off_data = data;
   endtask

   task automatic cyc();
      bit acc;
      wb.lsu_valid = off_vld;
      wb.lsu_rd    = off_rd;
      wb.lsu_data  = off_data;
      @(negedge clk);
      check("lsu_ready", 32'(wb.lsu_ready), 32'(reset_n && (q.size() < DEPTH)));
      check("busy1", 32'(wb.busy1), 32'(m_busy(wb.query1_id)));
      check("busy2", 32'(wb.busy2), 32'(m_busy(wb.query2_id)));
      m_step(acc);
      if (acc) off_vld = 1'b0;
      @(posedge clk);
      #1;
      check("rf_write_en", 32'(wb.rf_write_en), 32'(exp_en));
      check("rf_write_id", 32'(wb.rf_write_id), 32'(exp_id));
      check("rf_write_data", wb.rf_write_data, exp_data);
   endtask

   function automatic logic [4:0] rnd_rd();
      if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
      return 5'($urandom_range(0, 3));
   endfunction

   initial begin
      int idx;
      logic [4:0] full_rd [3];
      reset_n = 1'b0;
      off_vld = 1'b0;
      off_rd = 5'd0;
      off_data = 32'd0;
      drv(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      wb.lsu_valid = 1'b0;
      wb.lsu_rd = 5'd0;
      wb.lsu_data = 32'd0;
      @(posedge clk);
      #1;
      q.delete();
      exp_en = 1'b0;
      exp_id = 5'd0;
      exp_data = 32'd0;
      check("reset_en", 32'(wb.rf_write_en), 32'd0);
      check("reset_id", 32'(wb.rf_write_id), 32'd0);
      check("reset_data", wb.rf_write_data, 32'd0);
      cyc();
      reset_n = 1'b1;

      // ALU only
      drv(1'b1, 5'd5, 32'h1234, 5'd5, 5'd0);
      cyc();
      drv(1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
      cyc();
      cyc();

      // LSU bypass into an empty buffer
      offer(5'd7, 32'hAA);
      drv(1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
      cyc();
      cyc();
      cyc();

      // ALU and LSU in the same cycle
      offer(5'd4, 32'h4444);
      drv(1'b1, 5'd3, 32'h3333, 5'd4, 5'd3);
      cyc();
      drv(1'b0, 5'd0, 32'd0, 5'd4, 5'd3);
      cyc();
      cyc();

      // Buffer fills while the ALU owns the port
      full_rd = '{5'd10, 5'd11, 5'd12};
      idx = 0;
      for (int c = 0; c < 12; c++) begin
         if (!off_vld && idx < 3) begin
            offer(full_rd[idx], 32'hF00 + 32'(idx));
            idx++;
         end
         if (c < 6) drv(1'b1, 5'(c + 1), 32'h100 + 32'(c), 5'd10, 5'd12);
         else       drv(1'b0, 5'd0, 32'd0, 5'd11, 5'd12);
         cyc();
      end

      // ALU kills a buffered LSU result for the same register
      offer(5'd9, 32'h11);
      drv(1'b1, 5'd1, 32'h1, 5'd9, 5'd0);
      cyc();
      drv(1'b1, 5'd9, 32'h22, 5'd9, 5'd0);
      cyc();
      drv(1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
      cyc();
      cyc();
      cyc();

      // Reset with two results buffered
      offer(5'd20, 32'h2020);
      drv(1'b1, 5'd2, 32'h2, 5'd20, 5'd21);
      cyc();
      offer(5'd21, 32'h2121);
      cyc();
      reset_n = 1'b0;
      drv(1'b1, 5'd6, 32'h6, 5'd20, 5'd21);
      cyc();
      reset_n = 1'b1;
      drv(1'b0, 5'd0, 32'd0, 5'd20, 5'd21);
      cyc();
      cyc();

      // x0 results are never written
      offer(5'd0, 32'hDEAD);
      drv(1'b1, 5'd0, 32'hBEEF, 5'd0, 5'd0);
      cyc();
      drv(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      cyc();

      for (int c = 0; c < 3000; c++) begin
         reset_n = ($urandom_range(0, 99) != 0);
         if (!off_vld && $urandom_range(0, 1) == 1) offer(rnd_rd(), $urandom);
         drv($urandom_range(0, 1) == 1, rnd_rd(), $urandom, rnd_rd(), rnd_rd());
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter: DEPTH, 2, number of LSU result buffer entries (power of two, >=2).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 alu_valid  input  1  ALU result present this cycle; always accepted, no back-pressure.
REQ-005 alu_rd  input  5  ALU destination register id.
REQ-006 alu_data  input  32  ALU result value.
REQ-007 lsu_valid  input  1  load/long-latency result offered.
REQ-008 lsu_rd  input  5  LSU destination register id.
REQ-009 lsu_data  input  32  LSU result value.
REQ-010 lsu_ready  output  1  LSU result accepted when lsu_valid && lsu_ready.
REQ-011 rf_write_en  output  1  register file write enable (registered).
REQ-012 rf_write_id  output  5  register file write id (registered).
REQ-013 rf_write_data  output  32  register file write data (registered).
REQ-014 query1_id, query2_id  input  5 each  decode-stage source ids.
REQ-015 busy1, busy2  output  1 each  source has a pending, not-yet-written LSU result.

Function
REQ-016 The block SHALL merge ALU and LSU results onto the single register file write port, at most one write per cycle.
REQ-017 Results with rd == 0 SHALL be discarded: no write, no buffer entry; LSU handshake still completes.
REQ-018 Accepted LSU results SHALL enter a DEPTH-entry FIFO, each entry holding rd, data, live bit.
REQ-019 lsu_ready SHALL equal (count < DEPTH), computed from registered count only; no same-cycle dequeue credit.
REQ-020 Selection in cycle N, first match wins: alu_valid with rd != 0 -> ALU; else live FIFO head; else incoming accepted LSU with rd != 0 while FIFO empty (bypass, not enqueued).
REQ-021 The selected write SHALL appear on rf_write_* in cycle N+1 for exactly one cycle; otherwise rf_write_en = 0 and id/data hold previous values.
REQ-022 A FIFO head with live = 0 SHALL be popped without a write, and the arbiter SHALL then consider the next rule in REQ-020 in the same cycle.
REQ-023 Ordering: an ALU result in cycle N is younger than every FIFO entry and any LSU result accepted in cycle N.
REQ-024 On alu_valid with rd != 0, every FIFO entry (including one enqueued in cycle N) with matching rd SHALL have live cleared; a bypassing LSU result with matching rd SHALL be dropped.
REQ-025 Enqueue and dequeue in the same cycle SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-026 busyX SHALL be 1 iff queryX_id != 0 and matches rd of a live FIFO entry, combinational on registered state.
REQ-027 The output register value is not reported busy; the register file sees it at the next edge.

Reset
REQ-028 While reset_n = 0 at a rising edge: count = 0, pointers = 0, all live bits = 0, rf_write_en = 0, rf_write_id = 0, rf_write_data = 0.
REQ-029 Reset mid-operation SHALL discard all buffered LSU results and any pending output write; no write SHALL issue on the cycle after reset.
REQ-030 lsu_ready, busy1, busy2 SHALL be 0 during reset (lsu_ready forced low while reset_n = 0) and lsu_ready SHALL be 1 in the first cycle after release.

Verification
REQ-031 ALU only: alu_valid, rd=5, data=0x1234 in cycle N -> rf_write_en=1, id=5, data=0x1234 in N+1; en=0 in N+2.
REQ-032 Bypass: FIFO empty, no ALU, LSU rd=7, 0xAA accepted in N -> write id=7 in N+1; busy never asserted.
REQ-033 Conflict: ALU rd=3 and LSU rd=4 in N -> N+1 writes x3, N+2 writes x4; busy for query 4 is 1 during N+1 only.
REQ-034 Full: ALU valid every cycle, LSU offers 3 results, DEPTH=2 -> lsu_ready=0 after 2 accepted; third accepted only after ALU idles and one entry drains.
REQ-035 Kill: LSU rd=9, 0x11 buffered, then ALU rd=9, 0x22 -> only 0x22 written to x9; killed entry popped with no write; busy for 9 drops after the ALU cycle.
REQ-036 Reset with 2 entries buffered -> no rf writes after release; lsu_ready=1 and busy=0 in the first post-reset cycle; x0 results never written.
